m6809_bus_arbiter: RTL and testbench

//  Shares the SoC memory bus (16-bit address, 8-bit write data, rw_n) between the m6809 core
//  and a DMA/debug requester. Sits between m6809_core and the rom/ram decode in the integration

---
 rtl/m6809_pkg.sv | 17 +
 rtl/m6809_bus_arbiter.sv | 111 +++++++++++
 tb/tb_m6809_bus_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/m6809_pkg.sv
// Shared widths and arbiter state encoding for the m6809 integration layer.
// Combinational only; no latency.
// No flow control of its own.
package m6809_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    // Bus ownership states of the core/DMA arbiter
    typedef enum logic [1:0] {
        ARB_CPU     = 2'd0,
        ARB_HALTREQ = 2'd1,
        ARB_DMA     = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/m6809_bus_arbiter.sv
// Shares the memory bus between the m6809 core and a DMA/debug requester via halt_b handshake.
// Latency: req->halt_b low 1 cycle, halted->gnt 1 cycle, burst end->gnt low/halt_b high 1 cycle.
// Backpressure: core is stalled through halt_b; DMA waits on gnt, bursts capped at MAX_BURST beats.
module m6809_bus_arbiter
    import m6809_pkg::*;
#(
    parameter int MAX_BURST      = 16,
    parameter int MIN_CPU_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_dout,
    input  logic              cpu_rw_n,
    input  logic              cpu_halted,
    output logic              cpu_halt_b,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_dout,
    input  logic              dma_rw_n,
    output logic              dma_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dout,
    output logic              mem_rw_n
);

    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    // Keep the cooldown counter at least one bit wide so MIN_CPU_CYCLES=0 still elaborates
    localparam int COOL_W = (MIN_CPU_CYCLES > 0) ? $clog2(MIN_CPU_CYCLES + 1) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);
    localparam logic [COOL_W-1:0] COOL_INIT = COOL_W'(MIN_CPU_CYCLES);

    arb_state_t        r_state;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic [COOL_W-1:0] r_cool_cnt;

    logic w_dma_sel;
    logic w_halt_b;

    // Ownership FSM with burst-beat and post-release cooldown counters
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state    <= ARB_CPU;
            r_beat_cnt <= '0;
            r_cool_cnt <= '0;
        end else begin
            case (r_state)
                ARB_CPU: begin
                    if (r_cool_cnt != '0) begin
                        r_cool_cnt <= r_cool_cnt - 1'b1;
                    end
                    if (dma_req && (r_cool_cnt == '0)) begin
                        r_state <= ARB_HALTREQ;
                    end
                end
                ARB_HALTREQ: begin
                    // The halt ack wins over a withdrawn request: the core is already stopped
                    if (cpu_halted) begin
                        r_state    <= ARB_DMA;
                        r_beat_cnt <= '0;
                    end else if (!dma_req) begin
                        r_state <= ARB_CPU;
                    end
                end
                ARB_DMA: begin
                    if (dma_req) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (r_beat_cnt == BEAT_LAST) begin
                            r_state <= ARB_RELEASE;
                        end
                    end else begin
                        r_state <= ARB_RELEASE;
                    end
                end
                ARB_RELEASE: begin
                    // Wait for the core to actually resume before counting its guaranteed cycles
                    if (!cpu_halted) begin
                        r_state    <= ARB_CPU;
                        r_cool_cnt <= COOL_INIT;
                    end
                end
                default: begin
                    r_state <= ARB_CPU;
                end
            endcase
        end
    end

    // Handshake outputs decoded purely from the registered state
    always_comb begin
        w_dma_sel = (r_state == ARB_DMA);
        w_halt_b  = !((r_state == ARB_HALTREQ) || (r_state == ARB_DMA));
    end

    assign cpu_halt_b = w_halt_b;
    assign dma_gnt    = w_dma_sel;

    // Bus mux; an idle DMA cycle inside a grant is forced to a read so no stray write lands
    always_comb begin
        if (w_dma_sel) begin
            mem_addr = dma_addr;
            mem_dout = dma_dout;
            mem_rw_n = dma_rw_n | ~dma_req;
        end else begin
            mem_addr = cpu_addr;
            mem_dout = cpu_dout;
            mem_rw_n = cpu_rw_n;
        end
    end

endmodule

// File: tb/tb_m6809_bus_arbiter.sv
module tb_m6809_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        cpu_rw_n = 1'b1;
    logic        cpu_halted = 1'b0;
    logic        dma_req = 1'b0;
    logic [15:0] dma_addr = 16'h0000;
    logic [7:0]  dma_dout = 8'h00;
    logic        dma_rw_n = 1'b1;

    // Instance A: default MAX_BURST=16, MIN_CPU_CYCLES=4
    logic        halt_b_a, gnt_a, rw_n_a;
    logic [15:0] addr_a;
    logic [7:0]  dout_a;
    // Instance B: MAX_BURST=4, MIN_CPU_CYCLES=4
    logic        halt_b_b, gnt_b, rw_n_b;
    logic [15:0] addr_b;
    logic [7:0]  dout_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ram [0:255];

    always #5 clk = ~clk;

    m6809_bus_arbiter #(.MAX_BURST(16), .MIN_CPU_CYCLES(4)) u_dut_a (
        .clk(clk), .reset_b(reset_b),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_rw_n(cpu_rw_n),
        .cpu_halted(cpu_halted), .cpu_halt_b(halt_b_a),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_dout(dma_dout), .dma_rw_n(dma_rw_n),
        .dma_gnt(gnt_a),
        .mem_addr(addr_a), .mem_dout(dout_a), .mem_rw_n(rw_n_a)
    );

    m6809_bus_arbiter #(.MAX_BURST(4), .MIN_CPU_CYCLES(4)) u_dut_b (
        .clk(clk), .reset_b(reset_b),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_rw_n(cpu_rw_n),
        .cpu_halted(cpu_halted), .cpu_halt_b(halt_b_b),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_dout(dma_dout), .dma_rw_n(dma_rw_n),
        .dma_gnt(gnt_b),
        .mem_addr(addr_b), .mem_dout(dout_b), .mem_rw_n(rw_n_b)
    );

    // Memory model behind instance A
    always @(posedge clk) begin
        if (reset_b && !rw_n_a) ram[addr_a[7:0]] <= dout_a;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        dma_req    = 1'b0;
        cpu_halted = 1'b0;
        dma_rw_n   = 1'b1;
        reset_b    = 1'b0;
        tick();
        tick();
        reset_b = 1'b1;
    endtask

    int  cnt;
    logic seen_gnt;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;

        // 1: reset with a pending request
        cpu_addr = 16'h1234;
        dma_req  = 1'b1;
        reset_b  = 1'b0;
        tick();
        tick();
        chk("rst_halt_b", halt_b_a, 1'b1);
        chk("rst_gnt", gnt_a, 1'b0);
        chk("rst_mem_addr", addr_a, 16'h1234);
        chk("rst_gnt_b", gnt_b, 1'b0);

        // 2: basic grant, 5-beat write burst
        do_reset();
        tick();
        dma_req = 1'b1;
        tick();
        chk("t2_halt_b_low", halt_b_a, 1'b0);
        chk("t2_no_gnt_haltreq", gnt_a, 1'b0);
        chk("t2_core_drives", addr_a, 16'h1234);
        tick();
        tick();
        chk("t2_still_waiting", gnt_a, 1'b0);
        cpu_halted = 1'b1;
        dma_addr   = 16'h0040;
        dma_dout   = 8'hA5;
        dma_rw_n   = 1'b0;
        tick();
        chk("t2_gnt", gnt_a, 1'b1);
        chk("t2_mem_addr_dma", addr_a, 16'h0040);
        chk("t2_mem_rw_dma", rw_n_a, 1'b0);
        for (int i = 1; i < 5; i++) begin
            tick();
            dma_addr = 16'h0040 + 16'(i);
        end
        tick();
        dma_req  = 1'b0;
        dma_rw_n = 1'b1;
        #1;
        chk("t2_gnt_last", gnt_a, 1'b1);
        tick();
        chk("t2_rel_gnt", gnt_a, 1'b0);
        chk("t2_rel_halt_b", halt_b_a, 1'b1);
        cpu_halted = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) chk("t2_ram", {24'h0, ram[8'h40 + 8'(i)]}, 32'hA5);
        chk("t2_ram_past", {24'h0, ram[8'h45]}, 32'h00);

        // 3: burst cap on instance B, then cooldown
        do_reset();
        dma_req  = 1'b1;
        dma_rw_n = 1'b1;
        tick();
        chk("t3_halt_b_low", halt_b_b, 1'b0);
        cpu_halted = 1'b1;
        tick();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (gnt_b) cnt++;
            tick();
        end
        chk("t3_gnt_cycles", cnt, 4);
        chk("t3_rel_halt_b", halt_b_b, 1'b1);
        cpu_halted = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!halt_b_b) break;
            cnt++;
        end
        chk("t3_cool_cycles", cnt, 5);
        chk("t3_haltreq_again", halt_b_b, 1'b0);
        chk("t3_haltreq_nogn", gnt_b, 1'b0);

        // 4: request withdrawn during HALTREQ
        do_reset();
        seen_gnt = 1'b0;
        dma_req  = 1'b1;
        tick();
        seen_gnt |= gnt_a;
        chk("t4_halt_b_low", halt_b_a, 1'b0);
        tick();
        seen_gnt |= gnt_a;
        dma_req = 1'b0;
        tick();
        seen_gnt |= gnt_a;
        chk("t4_back_cpu", halt_b_a, 1'b1);
        tick();
        seen_gnt |= gnt_a;
        chk("t4_no_gnt", seen_gnt, 1'b0);
        dma_req = 1'b1;
        tick();
        chk("t4_no_cooldown", halt_b_a, 1'b0);

        // 5: request gap inside a burst
        do_reset();
        dma_req = 1'b1;
        tick();
        cpu_halted = 1'b1;
        dma_addr   = 16'h0080;
        dma_dout   = 8'h5A;
        dma_rw_n   = 1'b0;
        tick();
        tick();
        dma_req  = 1'b0;
        dma_addr = 16'h0090;
        #1;
        chk("t5_gap_rw_n", rw_n_a, 1'b1);
        chk("t5_gap_gnt", gnt_a, 1'b1);
        tick();
        chk("t5_end_gnt", gnt_a, 1'b0);
        chk("t5_end_halt_b", halt_b_a, 1'b1);
        chk("t5_ram_beat", {24'h0, ram[8'h80]}, 32'h5A);
        chk("t5_ram_gap", {24'h0, ram[8'h90]}, 32'h00);
        cpu_halted = 1'b0;
        dma_rw_n   = 1'b1;
        tick();

        // 6: reset at beat 2, then a clean re-arbitration
        do_reset();
        dma_req = 1'b1;
        tick();
        cpu_halted = 1'b1;
        dma_addr   = 16'h00C0;
        dma_dout   = 8'h3C;
        dma_rw_n   = 1'b0;
        tick();
        tick();
        tick();
        reset_b = 1'b0;
        #1;
        chk("t6_rst_gnt", gnt_a, 1'b0);
        chk("t6_rst_halt_b", halt_b_a, 1'b1);
        chk("t6_rst_rw_n", rw_n_a, 1'b1);
        chk("t6_rst_gnt_b", gnt_b, 1'b0);
        cpu_halted = 1'b0;
        dma_rw_n   = 1'b1;
        tick();
        chk("t6_ram_nopartial", {24'h0, ram[8'hC2]}, 32'h00);
        reset_b = 1'b1;
        tick();
        chk("t6_rearb_halt_b", halt_b_b, 1'b0);
        cpu_halted = 1'b1;
        tick();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (gnt_b) cnt++;
            tick();
        end
        chk("t6_full_burst", cnt, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
